// File: rtl/pc_gen.sv
// pc_gen: fetch-stage next-PC generator.
// Owns the fetch PC and selects the next PC each cycle from the exception
// redirect, EXE misprediction recovery, the ID taken prediction, or the
// sequential increment. Redirects seen while fetch is stalled are parked in a
// pending buffer and replayed when the stall releases.
// Optional feature: define PC_GEN_PERF_CNT_EN to build the performance
// counters; otherwise cnt_redirect / cnt_mispredict are tied to zero.
module pc_gen #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall_IF,
   input  logic        take_pre,
   input  logic [31:0] Target_pre,
   input  logic        mis_predict,
   input  logic [31:0] fix_PC,
   input  logic        exc_valid,
   input  logic [31:0] exc_PC,
   output logic [29:0] PC_IF,
   output logic        inst_req,
   output logic        Flush_IF,
   output logic        Flush_ID,
   output logic [31:0] cnt_redirect,
   output logic [31:0] cnt_mispredict
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HOLD
   } state_t;

   // Ordered so that a numerically larger source has higher priority.
   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PRE,
      SRC_MIS,
      SRC_EXC
   } src_t;

   state_t      state;
   src_t        redir_src;
   logic [29:0] redir_addr;
   src_t        pend_src;
   logic [29:0] pend_addr;
   logic        redir_any;
   logic        redir_applied;

   // Byte-offset bits of the redirect addresses are not used by word fetch.
   logic        unused_lsbs;
   assign unused_lsbs = ^{Target_pre[1:0], fix_PC[1:0], exc_PC[1:0]};

   // Pick the winning redirect source for this cycle.
   always_comb begin
      redir_src  = SRC_NONE;
      redir_addr = '0;
      if (exc_valid) begin
         redir_src  = SRC_EXC;
         redir_addr = exc_PC[31:2];
      end else if (mis_predict) begin
         redir_src  = SRC_MIS;
         redir_addr = fix_PC[31:2];
      end else if (take_pre) begin
         redir_src  = SRC_PRE;
         redir_addr = Target_pre[31:2];
      end
   end

   assign redir_any = (redir_src != SRC_NONE);

   // Flushes follow the live redirect inputs only; a replay from the pending
   // buffer never re-flushes. take_pre keeps the delay slot in IF.
   always_comb begin
      Flush_IF = exc_valid | mis_predict;
      Flush_ID = exc_valid;
   end

   // A redirect reaches PC_IF this cycle (used by the redirect counter).
   always_comb begin
      redir_applied = 1'b0;
      case (state)
         BOOT:    redir_applied = redir_any;
         RUN:     redir_applied = redir_any & ~Stall_IF;
         HOLD:    redir_applied = ~Stall_IF;
         default: redir_applied = 1'b0;
      endcase
   end

   // Fetch FSM: PC update, pending redirect buffer and fetch request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= BOOT;
         PC_IF     <= RESET_PC[31:2];
         inst_req  <= 1'b0;
         pend_src  <= SRC_NONE;
         pend_addr <= '0;
      end else begin
         case (state)
            BOOT: begin
               // Fetch starts at RESET_PC unless a redirect is already waiting.
               state    <= RUN;
               inst_req <= 1'b1;
               if (redir_any) begin
                  PC_IF <= redir_addr;
               end
            end
            RUN: begin
               inst_req <= 1'b1;
               if (!Stall_IF) begin
                  if (redir_any) begin
                     PC_IF <= redir_addr;
                  end else begin
                     PC_IF <= PC_IF + 30'd1;
                  end
               end else if (redir_any) begin
                  pend_src  <= redir_src;
                  pend_addr <= redir_addr;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               inst_req <= 1'b1;
               if (!Stall_IF) begin
                  // Same-cycle redirect of equal or higher priority beats the
                  // parked one, mirroring the overwrite rule while stalled.
                  if (redir_any && (redir_src >= pend_src)) begin
                     PC_IF <= redir_addr;
                  end else begin
                     PC_IF <= pend_addr;
                  end
                  pend_src  <= SRC_NONE;
                  pend_addr <= '0;
                  state     <= RUN;
               end else if (redir_any && (redir_src >= pend_src)) begin
                  pend_src  <= redir_src;
                  pend_addr <= redir_addr;
               end
            end
            default: begin
               state    <= BOOT;
               inst_req <= 1'b0;
               pend_src <= SRC_NONE;
            end
         endcase
      end
   end

`ifdef PC_GEN_PERF_CNT_EN
   // Count every cycle in which a redirect lands on PC_IF.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_redirect <= '0;
      end else if (redir_applied) begin
         cnt_redirect <= cnt_redirect + 32'd1;
      end
   end

   // Count mispredictions that are not masked by an exception.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_mispredict <= '0;
      end else if (mis_predict && !exc_valid) begin
         cnt_mispredict <= cnt_mispredict + 32'd1;
      end
   end
`else
   logic unused_redir_applied;
   assign unused_redir_applied = redir_applied;

   assign cnt_redirect   = '0;
   assign cnt_mispredict = '0;
`endif

endmodule
